// File: rtl/bp_cce_mem_cmd_credit_buffer.sv
// Credit-limited command FIFO between the CCE message unit and memory.
// Counts outstanding memory commands and refuses to issue more than credits_p at once.
module bp_cce_mem_cmd_credit_buffer #(
    parameter int msg_width_p = 128,
    parameter int els_p       = 2,
    parameter int credits_p   = 4
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic [msg_width_p-1:0]           mem_cmd_i,
    input  logic                             mem_cmd_v_i,
    output logic                             mem_cmd_ready_o,
    output logic [msg_width_p-1:0]           mem_cmd_o,
    output logic                             mem_cmd_v_o,
    input  logic                             mem_cmd_ready_i,
    input  logic                             mem_resp_v_i,
    input  logic                             mem_resp_yumi_i,
    output logic [$clog2(credits_p+1)-1:0]   credit_count_o,
    output logic                             credits_empty_o,
    output logic                             error_o
);

    localparam int ptr_w    = $clog2(els_p);
    localparam int occ_w    = $clog2(els_p + 1);
    localparam int credit_w = $clog2(credits_p + 1);
    localparam logic [occ_w-1:0]    occ_full   = occ_w'(els_p);
    localparam logic [credit_w-1:0] credit_max = credit_w'(credits_p);

    // Handshakes (valid/ready): a transfer happens on a rising edge where both
    // sides are high; valid never depends on ready, and ready never depends on
    // valid, so there are no combinational loops through this block.

    logic [msg_width_p-1:0] storage [els_p];
    logic [ptr_w-1:0]       wptr;
    logic [ptr_w-1:0]       rptr;
    logic [occ_w-1:0]       occupancy;
    logic [credit_w-1:0]    credit_count;
    logic                   error_flag;

    logic fifo_empty;
    logic fifo_full;
    logic enq;
    logic deq;
    logic resp_hs;

    assign fifo_empty = (occupancy == '0);
    assign fifo_full  = (occupancy == occ_full);

    assign mem_cmd_ready_o = !fifo_full;
    assign mem_cmd_v_o     = !fifo_empty && (credit_count < credit_max);
    assign mem_cmd_o       = storage[rptr];

    assign enq     = mem_cmd_v_i && mem_cmd_ready_o;
    assign deq     = mem_cmd_v_o && mem_cmd_ready_i;
    assign resp_hs = mem_resp_v_i && mem_resp_yumi_i;

    assign credit_count_o  = credit_count;
    assign credits_empty_o = (credit_count == '0) && fifo_empty;
    assign error_o         = error_flag;

    // Storage is not reset; occupancy alone decides which entries are live.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            storage[wptr] <= mem_cmd_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wptr         <= '0;
            rptr         <= '0;
            occupancy    <= '0;
            credit_count <= '0;
            error_flag   <= 1'b0;
        end else begin
            if (enq) begin
                wptr <= wptr + 1'b1;
            end
            if (deq) begin
                rptr <= rptr + 1'b1;
            end

            case ({enq, deq})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase

            // A response that arrives alongside an issue cancels it out, so an
            // empty count with a same-cycle issue is not an underflow.
            if (deq && !resp_hs) begin
                credit_count <= credit_count + 1'b1;
            end else if (!deq && resp_hs) begin
                if (credit_count != '0) begin
                    credit_count <= credit_count - 1'b1;
                end else begin
                    error_flag <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bp_cce_mem_cmd_credit_buffer.sv
// Directed bench for the memory command credit buffer (default parameters:
// 128-bit messages, 2-entry FIFO, 4 credits).
module tb_bp_cce_mem_cmd_credit_buffer;

  localparam int W = 128;
  localparam int CW = 3;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic [W-1:0]  mem_cmd_i;
  logic          mem_cmd_v_i;
  logic          mem_cmd_ready_o;
  logic [W-1:0]  mem_cmd_o;
  logic          mem_cmd_v_o;
  logic          mem_cmd_ready_i;
  logic          mem_resp_v_i;
  logic          mem_resp_yumi_i;
  logic [CW-1:0] credit_count_o;
  logic          credits_empty_o;
  logic          error_o;

  int checks = 0;
  int errors = 0;
  int deq_cnt = 0;
  logic [W-1:0] exp_q[$];

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  bp_cce_mem_cmd_credit_buffer #(
    .msg_width_p(W),
    .els_p(2),
    .credits_p(4)
  ) dut (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .mem_cmd_i(mem_cmd_i),
    .mem_cmd_v_i(mem_cmd_v_i),
    .mem_cmd_ready_o(mem_cmd_ready_o),
    .mem_cmd_o(mem_cmd_o),
    .mem_cmd_v_o(mem_cmd_v_o),
    .mem_cmd_ready_i(mem_cmd_ready_i),
    .mem_resp_v_i(mem_resp_v_i),
    .mem_resp_yumi_i(mem_resp_yumi_i),
    .credit_count_o(credit_count_o),
    .credits_empty_o(credits_empty_o),
    .error_o(error_o)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver: one clock, with the scoreboard watching both handshakes
  task automatic tick();
    logic enq_hs;
    logic deq_hs;
    enq_hs = reset_n_i && mem_cmd_v_i && mem_cmd_ready_o;
    deq_hs = reset_n_i && mem_cmd_v_o && mem_cmd_ready_i;
    if (deq_hs) begin
      check("sb_nonempty", W'(exp_q.size() != 0), W'(1));
      if (exp_q.size() != 0) check("sb_order", mem_cmd_o, exp_q.pop_front());
      deq_cnt++;
    end
    if (enq_hs) exp_q.push_back(mem_cmd_i);
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    mem_cmd_v_i = 1'b0;
    mem_cmd_i = '0;
    mem_cmd_ready_i = 1'b0;
    mem_resp_v_i = 1'b0;
    mem_resp_yumi_i = 1'b0;
    tick();
    reset_n_i = 1'b1;
    exp_q.delete();
    check("rst_ready", W'(mem_cmd_ready_o), W'(1));
    check("rst_v_o", W'(mem_cmd_v_o), W'(0));
    check("rst_credit", W'(credit_count_o), W'(0));
    check("rst_cempty", W'(credits_empty_o), W'(1));
    check("rst_error", W'(error_o), W'(0));
  endtask

  task automatic responses(input int n);
    mem_resp_v_i = 1'b1;
    mem_resp_yumi_i = 1'b1;
    for (int i = 0; i < n; i++) tick();
    mem_resp_v_i = 1'b0;
    mem_resp_yumi_i = 1'b0;
  endtask

  // offers n commands starting at base, feeding whenever the buffer is ready
  task automatic feed(input int n, input int base, input int cycles, input logic stall_pattern);
    int sent;
    sent = 0;
    for (int c = 0; c < cycles; c++) begin
      if (stall_pattern) mem_cmd_ready_i = (c % 3 != 2);
      mem_cmd_v_i = (sent < n);
      mem_cmd_i = W'(base + sent);
      if (mem_cmd_v_i && mem_cmd_ready_o) sent++;
      tick();
    end
    mem_cmd_v_i = 1'b0;
  endtask

  int d0;

  initial begin
    do_reset();

    // basic issue: one cycle to valid, credit taken on the handshake
    mem_cmd_ready_i = 1'b1;
    mem_cmd_v_i = 1'b1;
    mem_cmd_i = W'(32'h11);
    tick();
    mem_cmd_v_i = 1'b0;
    check("basic_v_o", W'(mem_cmd_v_o), W'(1));
    check("basic_data", mem_cmd_o, W'(32'h11));
    check("basic_credit0", W'(credit_count_o), W'(0));
    tick();
    check("basic_credit1", W'(credit_count_o), W'(1));
    check("basic_cempty", W'(credits_empty_o), W'(0));
    check("basic_v_o_idle", W'(mem_cmd_v_o), W'(0));
    mem_resp_yumi_i = 1'b1;
    tick();
    check("yumi_no_v", W'(credit_count_o), W'(1));
    responses(1);
    check("basic_credit_ret", W'(credit_count_o), W'(0));
    check("basic_cempty_ret", W'(credits_empty_o), W'(1));

    // full FIFO, no bypass of a full FIFO, order preserved
    mem_cmd_ready_i = 1'b0;
    mem_cmd_v_i = 1'b1;
    mem_cmd_i = W'(32'h21);
    check("full_ready0", W'(mem_cmd_ready_o), W'(1));
    tick();
    check("full_ready1", W'(mem_cmd_ready_o), W'(1));
    mem_cmd_i = W'(32'h22);
    tick();
    check("full_ready2", W'(mem_cmd_ready_o), W'(0));
    check("full_v_o", W'(mem_cmd_v_o), W'(1));
    check("full_head", mem_cmd_o, W'(32'h21));
    mem_cmd_i = W'(32'h23);
    mem_cmd_ready_i = 1'b1;
    tick();
    check("full_no_bypass", W'(mem_cmd_ready_o), W'(1));
    check("full_head2", mem_cmd_o, W'(32'h22));
    check("full_credit1", W'(credit_count_o), W'(1));
    mem_cmd_ready_i = 1'b0;
    tick();
    check("full_ready3", W'(mem_cmd_ready_o), W'(0));
    check("full_hold", mem_cmd_o, W'(32'h22));
    mem_cmd_v_i = 1'b0;
    mem_cmd_ready_i = 1'b1;
    tick();
    check("full_head3", mem_cmd_o, W'(32'h23));
    check("full_credit2", W'(credit_count_o), W'(2));
    tick();
    check("full_drained", W'(mem_cmd_v_o), W'(0));
    check("full_credit3", W'(credit_count_o), W'(3));
    mem_cmd_ready_i = 1'b0;
    responses(3);
    check("full_credit_ret", W'(credit_count_o), W'(0));
    check("full_cempty", W'(credits_empty_o), W'(1));

    // credit stall: five commands, four credits
    mem_cmd_ready_i = 1'b1;
    d0 = deq_cnt;
    feed(5, 32'h31, 12, 1'b0);
    check("stall_issued", W'(deq_cnt - d0), W'(4));
    check("stall_credit", W'(credit_count_o), W'(4));
    check("stall_v_o", W'(mem_cmd_v_o), W'(0));
    check("stall_head", mem_cmd_o, W'(32'h35));
    responses(1);
    check("stall_credit_ret", W'(credit_count_o), W'(3));
    check("stall_v_o_ret", W'(mem_cmd_v_o), W'(1));
    tick();
    check("stall_fifth", W'(deq_cnt - d0), W'(5));
    check("stall_credit_full", W'(credit_count_o), W'(4));

    // simultaneous issue and response at count 2
    responses(2);
    check("sim_credit_pre", W'(credit_count_o), W'(2));
    mem_cmd_v_i = 1'b1;
    mem_cmd_i = W'(32'h41);
    tick();
    mem_cmd_v_i = 1'b0;
    check("sim_v_o", W'(mem_cmd_v_o), W'(1));
    mem_resp_v_i = 1'b1;
    mem_resp_yumi_i = 1'b1;
    tick();
    mem_resp_v_i = 1'b0;
    mem_resp_yumi_i = 1'b0;
    check("sim_credit", W'(credit_count_o), W'(2));
    check("sim_empty", W'(mem_cmd_v_o), W'(0));
    responses(2);

    // pointer wrap: twelve commands with an irregular memory-ready pattern
    d0 = deq_cnt;
    for (int k = 0; k < 4; k++) begin
      feed(3, 32'h50 + 3 * k, 12, 1'b1);
      check("wrap_credit", W'(credit_count_o), W'(3));
      responses(3);
    end
    check("wrap_count", W'(deq_cnt - d0), W'(12));
    check("wrap_sb_empty", W'(exp_q.size()), W'(0));
    check("wrap_error", W'(error_o), W'(0));

    // underflow is sticky until reset
    responses(1);
    check("uf_error", W'(error_o), W'(1));
    check("uf_credit", W'(credit_count_o), W'(0));
    tick();
    check("uf_sticky", W'(error_o), W'(1));
    do_reset();

    // reset with two buffered entries and three outstanding
    mem_cmd_ready_i = 1'b1;
    feed(3, 32'h71, 8, 1'b0);
    mem_cmd_ready_i = 1'b0;
    feed(2, 32'h81, 4, 1'b0);
    check("mid_credit", W'(credit_count_o), W'(3));
    check("mid_full", W'(mem_cmd_ready_o), W'(0));
    check("mid_v_o", W'(mem_cmd_v_o), W'(1));
    do_reset();
    tick();
    check("post_rst_v_o", W'(mem_cmd_v_o), W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bp_cce_mem_cmd_credit_buffer.md
BP_CCE_MEM_CMD_CREDIT_BUFFER -- requirements
Module: bp_cce_mem_cmd_credit_buffer

Interface
REQ-001 SHALL have parameter msg_width_p, default 128: width of one memory command message in bits.
REQ-002 SHALL have parameter els_p, default 2: FIFO depth; legal values are powers of two, 2 or greater.
REQ-003 SHALL have parameter credits_p, default 4: maximum number of memory commands outstanding (1 or greater).
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 SHALL have port clk_i, input, 1 bit: clock; all state updates on the rising edge.
REQ-006 SHALL have port reset_n_i, input, 1 bit: synchronous active-low reset.
REQ-007 SHALL have port mem_cmd_i, input, msg_width_p bits: command from the CCE message unit.
REQ-008 SHALL have port mem_cmd_v_i, input, 1 bit: mem_cmd_i is valid.
REQ-009 SHALL have port mem_cmd_ready_o, output, 1 bit: buffer accepts mem_cmd_i this cycle.
REQ-010 SHALL have port mem_cmd_o, output, msg_width_p bits: head-of-FIFO command toward memory.
REQ-011 SHALL have port mem_cmd_v_o, output, 1 bit: mem_cmd_o is valid and a credit is available.
REQ-012 SHALL have port mem_cmd_ready_i, input, 1 bit: memory accepts mem_cmd_o.
REQ-013 SHALL have port mem_resp_v_i, input, 1 bit: memory response valid (monitored only).
REQ-014 SHALL have port mem_resp_yumi_i, input, 1 bit: CCE consumes the memory response (monitored only).
REQ-015 SHALL have port credit_count_o, output, clog2(credits_p+1) bits: number of outstanding commands.
REQ-016 SHALL have port credits_empty_o, output, 1 bit: no commands outstanding and FIFO empty; used for mode-switch drain.
REQ-017 SHALL have port error_o, output, 1 bit: sticky flag for credit underflow.

Function
REQ-018 SHALL enqueue on mem_cmd_v_i & mem_cmd_ready_o; mem_cmd_ready_o = (FIFO not full), independent of mem_cmd_v_i.
REQ-019 SHALL NOT bypass a full FIFO: when full, mem_cmd_ready_o = 0 even if a dequeue occurs in the same cycle.
REQ-020 SHALL NOT combinationally bypass input to output; minimum latency from enqueue to mem_cmd_v_o is 1 cycle.
REQ-021 SHALL drive mem_cmd_v_o = (FIFO not empty) & (credit_count_o < credits_p); mem_cmd_o = head entry, held stable while mem_cmd_v_o is high and mem_cmd_ready_i is low.
REQ-022 SHALL dequeue and increment credit_count_o on mem_cmd_v_o & mem_cmd_ready_i.
REQ-023 SHALL decrement credit_count_o on mem_resp_v_i & mem_resp_yumi_i when credit_count_o > 0.
REQ-024 SHALL leave credit_count_o unchanged when an increment and a decrement occur in the same cycle.
REQ-025 SHALL, on a response handshake while credit_count_o = 0 (with no same-cycle increment), hold the count at 0 and set error_o = 1 until reset.
REQ-026 SHALL implement read/write pointers of clog2(els_p) bits that wrap modulo els_p, plus a full/empty indication that is unambiguous when the pointers are equal.
REQ-027 SHALL allow a simultaneous enqueue and dequeue when the FIFO is neither full nor empty; occupancy is unchanged in that case.
REQ-028 SHALL drive credits_empty_o = (credit_count_o == 0) & (FIFO empty), as a registered-state function with no dependence on inputs.
REQ-029 SHALL ignore mem_resp_yumi_i when mem_resp_v_i = 0.

Reset
REQ-030 SHALL, while reset_n_i = 0 at a rising edge, clear the pointers, occupancy, credit_count_o and error_o; the FIFO storage contents are don't-care.
REQ-031 SHALL drive the following outputs from the cycle after a reset edge: mem_cmd_ready_o = 1, mem_cmd_v_o = 0, credit_count_o = 0, credits_empty_o = 1, error_o = 0.
REQ-032 SHALL, on reset asserted mid-operation, discard all buffered and in-flight accounting; no stale mem_cmd_v_o is driven after reset.

Verification
REQ-033 Basic: enqueue A=0x11 at cycle 0 with mem_cmd_ready_i=1 -> mem_cmd_v_o=1 and mem_cmd_o=0x11 at cycle 1; credit_count_o=1 at cycle 2; credits_empty_o=0.
REQ-034 Full: hold mem_cmd_ready_i=0 and enqueue 3 commands with els_p=2 -> mem_cmd_ready_o=0 after 2 accepts; the third is accepted only after one dequeue; order is preserved.
REQ-035 Credit stall: credits_p=4, issue 5 commands with no responses -> exactly 4 handshakes and mem_cmd_v_o=0 while credit_count_o=4; one response handshake -> the 5th command issues the next cycle.
REQ-036 Simultaneous: command handshake and response handshake in the same cycle at count=2 -> count stays 2; pointer wrap is exercised over 10 or more commands without loss or reorder.
REQ-037 Underflow: response handshake at count=0 -> error_o=1 sticky and count stays 0; reset_n_i=0 for one edge -> error_o=0.
REQ-038 Reset mid-operation: FIFO holding 2 entries and count=3, assert reset -> next cycle mem_cmd_v_o=0, count=0, credits_empty_o=1.
